// File: rtl/spec_frame_pkg.sv
// rtl/spec_frame_pkg.sv - shared FSM state, frame magic words and lane slicing for the spectrum framer
package spec_frame_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_TRAILER = 2'd3
  } state_e;

  localparam logic [15:0] FRAME_HDR_MAGIC = 16'hA55A;
  localparam logic [15:0] FRAME_TRL_MAGIC = 16'h5AA5;

  localparam int LANE_W  = 16;
  localparam int Y0_LSB  = 48;
  localparam int Y0Z_LSB = 32;
  localparam int Y1_LSB  = 16;
  localparam int Y1Z_LSB = 0;

  // Modulo-2^16 sum of the four output lanes of one payload word.
  function automatic logic [15:0] lane_sum(input logic [63:0] w);
    lane_sum = w[Y0_LSB +: LANE_W] + w[Y0Z_LSB +: LANE_W]
             + w[Y1_LSB +: LANE_W] + w[Y1Z_LSB +: LANE_W];
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through synchronous FIFO with full/empty/count
module sync_fifo_fwft #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  // A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
  assign w_rd = rd_en_i && (r_count != '0);
  assign w_wr = wr_en_i && ((r_count != (AW+1)'(DEPTH)) || w_rd);

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data_o = r_mem[r_rd_ptr];
  assign full_o    = (r_count == (AW+1)'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;

endmodule

// File: rtl/spec_frame_tx.sv
// rtl/spec_frame_tx.sv - frames accumulated spectrum words as header/payload/trailer on four 16-bit lanes
module spec_frame_tx #(
  parameter int          DATA_W     = 64,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] HDR_MAGIC  = spec_frame_pkg::FRAME_HDR_MAGIC,
  parameter logic [15:0] TRL_MAGIC  = spec_frame_pkg::FRAME_TRL_MAGIC
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              frame_start_i,
  input  logic [15:0]       n_words_i,
  input  logic [15:0]       pulse_count_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  input  logic              err_clr_i,
  output logic [15:0]       y0_o,
  output logic [15:0]       y0z_o,
  output logic [15:0]       y1_o,
  output logic [15:0]       y1z_o,
  output logic              data_valid_o,
  output logic              busy_o,
  output logic [15:0]       frame_count_o,
  output logic              overflow_o,
  output logic              start_err_o
);

  import spec_frame_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [15:0]       r_n_words;
  logic [15:0]       r_pulse_cnt;
  logic [15:0]       r_pay_cnt;
  logic [15:0]       r_csum;
  logic [15:0]       r_frame_count;
  logic              r_trl_done;
  logic [DATA_W-1:0] r_dout;
  logic              r_dv;
  logic              r_busy;
  logic              r_ovf;
  logic              r_serr;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic [CW-1:0]     w_fifo_cnt_unused;
  logic [15:0]       w_cnt_inc;
  logic              w_emit;
  logic [DATA_W-1:0] w_emit_data;
  logic              w_drop;
  logic              w_serr_set;
  logic              w_start;

  assign w_start    = (r_state == S_IDLE) && frame_start_i;
  assign w_push     = valid_i && (r_state != S_IDLE);
  assign w_drop     = w_push && w_full && !w_pop;
  assign w_serr_set = frame_start_i && (r_state != S_IDLE);
  assign w_cnt_inc  = r_pay_cnt + 16'd1;

  sync_fifo_fwft #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (w_push),
    .wr_data_i (data_i),
    .rd_en_i   (w_pop),
    .rd_data_o (w_head),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .count_o   (w_fifo_cnt_unused)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_emit      = 1'b0;
    w_emit_data = '0;
    case (r_state)
      S_IDLE: begin
        if (frame_start_i) w_state_nxt = S_HEADER;
      end
      S_HEADER: begin
        w_emit      = 1'b1;
        w_emit_data = {HDR_MAGIC, r_frame_count, r_n_words, r_pulse_cnt};
        w_state_nxt = (r_n_words == 16'd0) ? S_TRAILER : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_emit      = 1'b1;
          w_emit_data = w_head;
          if (w_cnt_inc == r_n_words) w_state_nxt = S_TRAILER;
        end
      end
      S_TRAILER: begin
        w_emit      = 1'b1;
        w_emit_data = {TRL_MAGIC, r_frame_count, r_pay_cnt, r_csum};
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // busy and frame_count trail the FSM by one edge so they change together with the output word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_n_words     <= '0;
      r_pulse_cnt   <= '0;
      r_pay_cnt     <= '0;
      r_csum        <= '0;
      r_frame_count <= '0;
      r_trl_done    <= 1'b0;
      r_dout        <= '0;
      r_dv          <= 1'b0;
      r_busy        <= 1'b0;
      r_ovf         <= 1'b0;
      r_serr        <= 1'b0;
    end else begin
      if (w_start) begin
        r_n_words   <= n_words_i;
        r_pulse_cnt <= pulse_count_i;
        r_pay_cnt   <= '0;
        r_csum      <= '0;
      end else if (w_pop) begin
        r_pay_cnt <= w_cnt_inc;
        r_csum    <= r_csum + lane_sum(w_head);
      end
      r_dv <= w_emit;
      if (w_emit) r_dout <= w_emit_data;
      r_busy     <= (r_state != S_IDLE);
      r_trl_done <= (r_state == S_TRAILER);
      if (r_trl_done) r_frame_count <= r_frame_count + 16'd1;
      r_ovf  <= w_drop     | (r_ovf  & ~err_clr_i);
      r_serr <= w_serr_set | (r_serr & ~err_clr_i);
    end
  end

  assign y0_o          = r_dout[Y0_LSB  +: LANE_W];
  assign y0z_o         = r_dout[Y0Z_LSB +: LANE_W];
  assign y1_o          = r_dout[Y1_LSB  +: LANE_W];
  assign y1z_o         = r_dout[Y1Z_LSB +: LANE_W];
  assign data_valid_o  = r_dv;
  assign busy_o        = r_busy;
  assign frame_count_o = r_frame_count;
  assign overflow_o    = r_ovf;
  assign start_err_o   = r_serr;

endmodule

// File: tb/tb_spec_frame_tx.sv
// tb/tb_spec_frame_tx.sv - directed self-checking bench for spec_frame_tx
module tb_spec_frame_tx;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        frame_start_i;
  logic [15:0] n_words_i;
  logic [15:0] pulse_count_i;
  logic [63:0] data_i;
  logic        valid_i;
  logic        err_clr_i;
  logic [15:0] y0_o, y0z_o, y1_o, y1z_o;
  logic        data_valid_o;
  logic        busy_o;
  logic [15:0] frame_count_o;
  logic        overflow_o;
  logic        start_err_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_fc  = 16'd0;
  logic [63:0] fill_q [$];
  logic [63:0] w_y;

  assign w_y = {y0_o, y0z_o, y1_o, y1z_o};

  always #5 clk_i = ~clk_i;

  spec_frame_tx #(
    .DATA_W     (64),
    .FIFO_DEPTH (16),
    .HDR_MAGIC  (16'hA55A),
    .TRL_MAGIC  (16'h5AA5)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .frame_start_i (frame_start_i),
    .n_words_i     (n_words_i),
    .pulse_count_i (pulse_count_i),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .err_clr_i     (err_clr_i),
    .y0_o          (y0_o),
    .y0z_o         (y0z_o),
    .y1_o          (y1_o),
    .y1z_o         (y1z_o),
    .data_valid_o  (data_valid_o),
    .busy_o        (busy_o),
    .frame_count_o (frame_count_o),
    .overflow_o    (overflow_o),
    .start_err_o   (start_err_o)
  );

  // Drives one cycle of inputs from a negedge and returns at the next negedge.
  task automatic cyc(input logic fs, input logic v, input logic [63:0] d, input logic clr);
    frame_start_i = fs;
    valid_i       = v;
    data_i        = d;
    err_clr_i     = clr;
    @(negedge clk_i);
  endtask

  // Eight empty frames with valid held high: each pushes its HEADER and TRAILER word.
  task automatic fill_fifo();
    n_words_i     = 16'd0;
    pulse_count_i = 16'd0;
    fill_q.delete();
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < 3; c++) begin
        cyc(c == 0, 1'b1, 64'(3 * f + c), 1'b0);
        if (c != 0) fill_q.push_back(64'(3 * f + c));
      end
    end
    exp_fc = exp_fc + 16'd8;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; frame_start_i = 1'b0; valid_i = 1'b0; err_clr_i = 1'b0;
    data_i = '0; n_words_i = '0; pulse_count_i = '0;
    repeat (3) @(negedge clk_i);
    n_tests++; if (w_y !== 64'h0) begin n_fail++; $display("FAIL rst_lanes: got %h expected 0", w_y); end
    n_tests++; if (data_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_dv: got %b expected 0", data_valid_o); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
    n_tests++; if (frame_count_o !== 16'h0) begin n_fail++; $display("FAIL rst_fc: got %h expected 0", frame_count_o); end
    n_tests++; if ({overflow_o, start_err_o} !== 2'b00) begin n_fail++; $display("FAIL rst_flags: got %b expected 00", {overflow_o, start_err_o}); end
    rst_n_i = 1'b1;
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_tests++; if ({busy_o, data_valid_o} !== 2'b00) begin n_fail++; $display("FAIL rst_idle: got %b expected 00", {busy_o, data_valid_o}); end
  endtask

  task automatic test_basic();
    logic [63:0] w;
    w = 64'h0001_0002_0003_0004;
    n_words_i = 16'd3; pulse_count_i = 16'd100;
    cyc(1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0);
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_busy_T: got %b expected 0", busy_o); end
    cyc(1'b0, 1'b1, w, 1'b0);
    n_tests++; if ({data_valid_o, busy_o, w_y} !== {2'b11, 64'hA55A_0000_0003_0064}) begin n_fail++; $display("FAIL basic_header: got %b%b %h expected 11 a55a000000030064", data_valid_o, busy_o, w_y); end
    cyc(1'b0, 1'b1, w, 1'b0);
    n_tests++; if ({data_valid_o, w_y} !== {1'b1, w}) begin n_fail++; $display("FAIL basic_word0: got %b %h expected 1 %h", data_valid_o, w_y, w); end
    cyc(1'b0, 1'b1, w, 1'b0);
    n_tests++; if ({data_valid_o, w_y} !== {1'b1, w}) begin n_fail++; $display("FAIL basic_word1: got %b %h expected 1 %h", data_valid_o, w_y, w); end
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_tests++; if ({data_valid_o, w_y} !== {1'b1, w}) begin n_fail++; $display("FAIL basic_word2: got %b %h expected 1 %h", data_valid_o, w_y, w); end
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_tests++; if ({data_valid_o, busy_o, w_y} !== {2'b11, 64'h5AA5_0000_0003_001E}) begin n_fail++; $display("FAIL basic_trailer: got %b%b %h expected 11 5aa500000003001e", data_valid_o, busy_o, w_y); end
    n_tests++; if (frame_count_o !== 16'd0) begin n_fail++; $display("FAIL basic_fc_in_trl: got %h expected 0", frame_count_o); end
    cyc(1'b0, 1'b0, '0, 1'b0);
    exp_fc = 16'd1;
    n_tests++; if ({busy_o, data_valid_o, frame_count_o} !== {2'b00, exp_fc}) begin n_fail++; $display("FAIL basic_end: got %b%b %h expected 00 %h", busy_o, data_valid_o, frame_count_o, exp_fc); end
    n_tests++; if (w_y !== 64'h5AA5_0000_0003_001E) begin n_fail++; $display("FAIL basic_hold: got %h expected 5aa500000003001e", w_y); end
  endtask

  task automatic test_back_to_back_empty();
    n_words_i = 16'd0; pulse_count_i = 16'd7;
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_tests++; if ({data_valid_o, w_y} !== {1'b1, 16'hA55A, exp_fc, 32'h0000_0007}) begin n_fail++; $display("FAIL empty_header: got %b %h expected 1 a55a%h00000007", data_valid_o, w_y, exp_fc); end
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_tests++; if ({data_valid_o, w_y} !== {1'b1, 16'h5AA5, exp_fc, 32'h0}) begin n_fail++; $display("FAIL empty_trailer: got %b %h expected 1 5aa5%h00000000", data_valid_o, w_y, exp_fc); end
    cyc(1'b1, 1'b0, '0, 1'b0);
    exp_fc = exp_fc + 16'd1;
    n_tests++; if ({busy_o, data_valid_o, frame_count_o} !== {2'b00, exp_fc}) begin n_fail++; $display("FAIL b2b_fall: got %b%b %h expected 00 %h", busy_o, data_valid_o, frame_count_o, exp_fc); end
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_tests++; if ({busy_o, data_valid_o, w_y} !== {2'b11, 16'hA55A, exp_fc, 32'h0000_0007}) begin n_fail++; $display("FAIL b2b_header: got %b%b %h expected 11 a55a%h00000007", busy_o, data_valid_o, w_y, exp_fc); end
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_tests++; if ({data_valid_o, w_y} !== {1'b1, 16'h5AA5, exp_fc, 32'h0}) begin n_fail++; $display("FAIL b2b_trailer: got %b %h expected 1 5aa5%h00000000", data_valid_o, w_y, exp_fc); end
    cyc(1'b0, 1'b0, '0, 1'b0);
    exp_fc = exp_fc + 16'd1;
    n_tests++; if ({busy_o, frame_count_o} !== {1'b0, exp_fc}) begin n_fail++; $display("FAIL b2b_end: got %b %h expected 0 %h", busy_o, frame_count_o, exp_fc); end
  endtask

  task automatic test_start_err();
    logic [63:0] d1, d2;
    d1 = 64'h0010_0020_0030_0040;
    d2 = 64'hFFFF_0001_0000_0002;
    n_words_i = 16'd2; pulse_count_i = 16'd5;
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, d1, 1'b0);
    n_tests++; if (start_err_o !== 1'b0) begin n_fail++; $display("FAIL serr_pre: got %b expected 0", start_err_o); end
    n_words_i = 16'd9; pulse_count_i = 16'd9;
    cyc(1'b1, 1'b1, d2, 1'b0);
    n_tests++; if ({start_err_o, data_valid_o, w_y} !== {2'b11, d1}) begin n_fail++; $display("FAIL serr_set: got %b%b %h expected 11 %h", start_err_o, data_valid_o, w_y, d1); end
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_tests++; if (w_y !== d2) begin n_fail++; $display("FAIL serr_word1: got %h expected %h", w_y, d2); end
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_tests++; if (w_y !== {16'h5AA5, exp_fc, 32'h0002_00A2}) begin n_fail++; $display("FAIL serr_trailer: got %h expected 5aa5%h000200a2", w_y, exp_fc); end
    cyc(1'b0, 1'b0, '0, 1'b0);
    exp_fc = exp_fc + 16'd1;
    n_tests++; if ({busy_o, start_err_o} !== 2'b01) begin n_fail++; $display("FAIL serr_sticky: got %b expected 01", {busy_o, start_err_o}); end
    cyc(1'b0, 1'b0, '0, 1'b1);
    n_tests++; if (start_err_o !== 1'b0) begin n_fail++; $display("FAIL serr_clr: got %b expected 0", start_err_o); end
    n_words_i = 16'd0;
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1);
    n_tests++; if (start_err_o !== 1'b1) begin n_fail++; $display("FAIL serr_set_wins: got %b expected 1", start_err_o); end
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    exp_fc = exp_fc + 16'd1;
    cyc(1'b0, 1'b0, '0, 1'b1);
    n_tests++; if ({start_err_o, frame_count_o} !== {1'b0, exp_fc}) begin n_fail++; $display("FAIL serr_clr2: got %b %h expected 0 %h", start_err_o, frame_count_o, exp_fc); end
  endtask

  task automatic test_overflow();
    // Full FIFO, pop and push in the same cycle: nothing dropped.
    fill_fifo();
    n_tests++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_fill: got %b expected 0", overflow_o); end
    fill_q.push_back(64'h99);
    n_words_i = 16'd17; pulse_count_i = 16'd0;
    cyc(1'b1, 1'b1, 64'hEE, 1'b0);
    n_tests++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_idle_discard: got %b expected 0", overflow_o); end
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_tests++; if (w_y !== {16'hA55A, exp_fc, 32'h0011_0000}) begin n_fail++; $display("FAIL ovfA_header: got %h expected a55a%h00110000", w_y, exp_fc); end
    for (int i = 0; i < 17; i++) begin
      cyc(1'b0, i == 0, 64'h99, 1'b0);
      n_tests++; if ({data_valid_o, w_y} !== {1'b1, fill_q[i]}) begin n_fail++; $display("FAIL ovfA_word%0d: got %b %h expected 1 %h", i, data_valid_o, w_y, fill_q[i]); end
    end
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_tests++; if ({overflow_o, w_y} !== {1'b0, 16'h5AA5, exp_fc, 32'h0011_0159}) begin n_fail++; $display("FAIL ovfA_trailer: got %b %h expected 0 5aa5%h00110159", overflow_o, w_y, exp_fc); end
    cyc(1'b0, 1'b0, '0, 1'b0);
    exp_fc = exp_fc + 16'd1;
    // Full FIFO, push in HEADER with no pop: exactly that word is dropped.
    fill_fifo();
    n_words_i = 16'd16; pulse_count_i = 16'd0;
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 64'h77, 1'b0);
    n_tests++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovfB_set: got %b expected 1", overflow_o); end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b0);
      n_tests++; if ({data_valid_o, w_y} !== {1'b1, fill_q[i]}) begin n_fail++; $display("FAIL ovfB_word%0d: got %b %h expected 1 %h", i, data_valid_o, w_y, fill_q[i]); end
    end
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_tests++; if (w_y !== {16'h5AA5, exp_fc, 32'h0010_00C0}) begin n_fail++; $display("FAIL ovfB_trailer: got %h expected 5aa5%h001000c0", w_y, exp_fc); end
    cyc(1'b0, 1'b0, '0, 1'b0);
    exp_fc = exp_fc + 16'd1;
    n_tests++; if ({busy_o, overflow_o} !== 2'b01) begin n_fail++; $display("FAIL ovfB_sticky: got %b expected 01", {busy_o, overflow_o}); end
    cyc(1'b0, 1'b0, '0, 1'b1);
    n_tests++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", overflow_o); end
  endtask

  task automatic test_fc_wrap();
    force dut.r_frame_count = 16'hFFFF;
    #1;
    release dut.r_frame_count;
    n_words_i = 16'd0; pulse_count_i = 16'd0;
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_tests++; if (w_y !== 64'hA55A_FFFF_0000_0000) begin n_fail++; $display("FAIL wrap_header: got %h expected a55affff00000000", w_y); end
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_tests++; if (w_y !== 64'h5AA5_FFFF_0000_0000) begin n_fail++; $display("FAIL wrap_trailer: got %h expected 5aa5ffff00000000", w_y); end
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_tests++; if (frame_count_o !== 16'h0000) begin n_fail++; $display("FAIL wrap_fc: got %h expected 0000", frame_count_o); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] r1, r2, nw;
    r1 = 64'h1111_2222_3333_4444;
    r2 = 64'h5555_6666_7777_8888;
    nw = 64'h0001_0001_0001_0001;
    n_words_i = 16'd5; pulse_count_i = 16'd9;
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, r1, 1'b0);
    cyc(1'b0, 1'b1, r2, 1'b0);
    n_tests++; if ({busy_o, data_valid_o, w_y} !== {2'b11, r1}) begin n_fail++; $display("FAIL rmid_pre: got %b%b %h expected 11 %h", busy_o, data_valid_o, w_y, r1); end
    valid_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    n_tests++; if ({w_y, data_valid_o, busy_o, frame_count_o, overflow_o, start_err_o} !== '0) begin n_fail++; $display("FAIL rmid_async: got %h %b%b %h %b%b expected all 0", w_y, data_valid_o, busy_o, frame_count_o, overflow_o, start_err_o); end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    n_words_i = 16'd1; pulse_count_i = 16'd2;
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, nw, 1'b0);
    n_tests++; if (w_y !== 64'hA55A_0000_0001_0002) begin n_fail++; $display("FAIL rmid_header: got %h expected a55a000000010002", w_y); end
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_tests++; if ({data_valid_o, w_y} !== {1'b1, nw}) begin n_fail++; $display("FAIL rmid_fifo_empty: got %b %h expected 1 %h", data_valid_o, w_y, nw); end
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_tests++; if (w_y !== 64'h5AA5_0000_0001_0004) begin n_fail++; $display("FAIL rmid_trailer: got %h expected 5aa5000000010004", w_y); end
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_tests++; if ({busy_o, frame_count_o} !== {1'b0, 16'h0001}) begin n_fail++; $display("FAIL rmid_fc: got %b %h expected 0 0001", busy_o, frame_count_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back_empty();
    test_start_err();
    test_overflow();
    test_fc_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish before 100000ns");
    $fatal(1);
  end

endmodule
